// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Decode-side handshake of the fetch unit: the master offers {instr, pc} with valid,
// the slave accepts with ready; a transfer happens on a cycle where valid & ready are both high.
interface fetch_if;
    import fetch_pkg::*;

    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
    logic            ready;

    modport master (output instr, output pc, output valid, input ready);
    modport slave  (input instr, input pc, input valid, output ready);

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush takes priority over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  fetch_entry_t           entry_i,
    output fetch_entry_t           head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (do_pop && !do_push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i) mem_q[wr_ptr_q] <= entry_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, ROM address drive and prefetch FIFO toward decode.
// Optional FETCH_PERF_EN adds fetch/flush event counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    fetch_if.master         dec_if
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     fetch_count_o,
    output logic [31:0]     flush_count_o
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            push, pop;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
    fetch_entry_t    head, tail;

    // The ROM address is the PC register alone, so ready/redirect never reach it combinationally.
    assign imem_addr_o = pc_q;

    assign pop  = dec_if.valid & dec_if.ready & ~redirect_i;
    assign push = ~redirect_i & (~fifo_full | pop);

    assign tail.pc    = pc_q;
    assign tail.instr = imem_data_i;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i & ~32'd3;
        end else if (push) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (push),
        .pop_i   (pop),
        .entry_i (tail),
        .head_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // An empty FIFO presents a NOP at pc 0 rather than stale storage.
    assign dec_if.valid = (fifo_count != '0);
    assign dec_if.instr = fifo_empty ? INSTR_NOP : head.instr;
    assign dec_if.pc    = fifo_empty ? '0 : head.pc;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + (push ? 32'd1 : 32'd0);
        flush_count_d = flush_count_q + (redirect_i ? 32'(fifo_count) : 32'd0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count_o = fetch_count_q;
    assign flush_count_o = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, randomized run against a queue model, and a wrap-around instance.
module tb_fetch_unit;
    import fetch_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    // instance A: RESET_PC 0, depth 2
    logic        rst_a, redir_a;
    logic [31:0] rpc_a, addr_a, data_a;
    fetch_if ifa();
    assign data_a = rom(addr_a);

    // instance B: RESET_PC near wrap, depth 4
    logic        rst_b, redir_b;
    logic [31:0] rpc_b, addr_b, data_b;
    fetch_if ifb();
    assign data_b = rom(addr_b);

`ifdef FETCH_PERF_EN
    logic [31:0] fcnt_a, flcnt_a, fcnt_b, flcnt_b;
`endif

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .imem_addr_o(addr_a), .imem_data_i(data_a),
        .redirect_i(redir_a), .redirect_pc_i(rpc_a), .dec_if(ifa)
`ifdef FETCH_PERF_EN
        , .fetch_count_o(fcnt_a), .flush_count_o(flcnt_a)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .imem_addr_o(addr_b), .imem_data_i(data_b),
        .redirect_i(redir_b), .redirect_pc_i(rpc_b), .dec_if(ifb)
`ifdef FETCH_PERF_EN
        , .fetch_count_o(fcnt_b), .flush_count_o(flcnt_b)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: apply inputs, let one rising edge pass, settle
    task automatic drive_a(input logic rst, input logic redir, input logic [31:0] rpc, input logic rdy);
        rst_a     = rst;
        redir_a   = redir;
        rpc_a     = rpc;
        ifa.ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_b();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: prefetch contents as a queue of {pc, instr}
    logic [63:0] exp_q[$];
    logic [31:0] m_pc, m_fetch, m_flush;

    task automatic model_step(input logic rst, input logic redir, input logic [31:0] rpc, input logic rdy);
        if (rst) begin
            exp_q.delete();
            m_pc = 32'h0; m_fetch = 0; m_flush = 0;
        end else if (redir) begin
            m_flush = m_flush + exp_q.size();
            exp_q.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
            if (exp_q.size() < 2) begin
                exp_q.push_back({m_pc, rom(m_pc)});
                m_pc = m_pc + 32'd4;
                m_fetch = m_fetch + 1;
            end
        end
    endtask

    task automatic check_model();
        logic [63:0] h;
        h = (exp_q.size() > 0) ? exp_q[0] : {32'h0, INSTR_NOP};
        chk("rnd_valid", {31'b0, ifa.valid}, {31'b0, exp_q.size() > 0});
        chk("rnd_pc",    ifa.pc,    h[63:32]);
        chk("rnd_instr", ifa.instr, h[31:0]);
        chk("rnd_addr",  addr_a,    m_pc);
`ifdef FETCH_PERF_EN
        chk("rnd_fetch_cnt", fcnt_a,  m_fetch);
        chk("rnd_flush_cnt", flcnt_a, m_flush);
`endif
    endtask

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    function automatic vec_t mk(logic rst, logic redir, logic [31:0] rpc, logic rdy,
                                logic v, logic [31:0] pc, logic [31:0] addr);
        vec_t r;
        r.rst = rst; r.redir = redir; r.rpc = rpc; r.rdy = rdy;
        r.exp_valid = v; r.exp_pc = pc; r.exp_addr = addr;
        return r;
    endfunction

    vec_t tbl[23];

    initial begin
        rst_a = 1'b1; redir_a = 1'b0; rpc_a = '0; ifa.ready = 1'b1;
        rst_b = 1'b1; redir_b = 1'b0; rpc_b = '0; ifb.ready = 1'b1;

        // streaming after reset
        tbl[0]  = mk(1, 0, 32'h0,   1, 0, 32'h0,   32'h0);
        tbl[1]  = mk(0, 0, 32'h0,   1, 1, 32'h0,   32'h4);
        tbl[2]  = mk(0, 0, 32'h0,   1, 1, 32'h4,   32'h8);
        tbl[3]  = mk(0, 0, 32'h0,   1, 1, 32'h8,   32'hC);
        // stall five cycles, then release
        tbl[4]  = mk(1, 0, 32'h0,   1, 0, 32'h0,   32'h0);
        tbl[5]  = mk(0, 0, 32'h0,   0, 1, 32'h0,   32'h4);
        tbl[6]  = mk(0, 0, 32'h0,   0, 1, 32'h0,   32'h8);
        tbl[7]  = mk(0, 0, 32'h0,   0, 1, 32'h0,   32'h8);
        tbl[8]  = mk(0, 0, 32'h0,   0, 1, 32'h0,   32'h8);
        tbl[9]  = mk(0, 0, 32'h0,   0, 1, 32'h0,   32'h8);
        tbl[10] = mk(0, 0, 32'h0,   1, 1, 32'h4,   32'hC);
        tbl[11] = mk(0, 0, 32'h0,   1, 1, 32'h8,   32'h10);
        // redirect to a misaligned target with a full FIFO
        tbl[12] = mk(0, 0, 32'h0,   0, 1, 32'h8,   32'h10);
        tbl[13] = mk(0, 1, 32'h103, 1, 0, 32'h0,   32'h100);
        tbl[14] = mk(0, 0, 32'h0,   1, 1, 32'h100, 32'h104);
        tbl[15] = mk(0, 0, 32'h0,   1, 1, 32'h104, 32'h108);
        // back-to-back redirects
        tbl[16] = mk(0, 1, 32'h40,  1, 0, 32'h0,   32'h40);
        tbl[17] = mk(0, 1, 32'h80,  1, 0, 32'h0,   32'h80);
        tbl[18] = mk(0, 0, 32'h0,   1, 1, 32'h80,  32'h84);
        tbl[19] = mk(0, 0, 32'h0,   1, 1, 32'h84,  32'h88);
        // reset with two entries held
        tbl[20] = mk(0, 0, 32'h0,   0, 1, 32'h84,  32'h8C);
        tbl[21] = mk(1, 0, 32'h0,   1, 0, 32'h0,   32'h0);
        tbl[22] = mk(0, 0, 32'h0,   1, 1, 32'h0,   32'h4);

        for (int i = 0; i < 23; i++) begin
            logic [31:0] ei;
            drive_a(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].rdy);
            ei = tbl[i].exp_valid ? rom(tbl[i].exp_pc) : INSTR_NOP;
            chk($sformatf("vec%0d_valid", i), {31'b0, ifa.valid}, {31'b0, tbl[i].exp_valid});
            chk($sformatf("vec%0d_pc", i),    ifa.pc,    tbl[i].exp_pc);
            chk($sformatf("vec%0d_instr", i), ifa.instr, ei);
            chk($sformatf("vec%0d_addr", i),  addr_a,    tbl[i].exp_addr);
        end

        // counters after reset and after flushing a full FIFO
        drive_a(1, 0, 32'h0, 0);
`ifdef FETCH_PERF_EN
        chk("perf_fetch_rst", fcnt_a, 32'd0);
        chk("perf_flush_rst", flcnt_a, 32'd0);
`endif
        drive_a(0, 0, 32'h0, 0);
        drive_a(0, 0, 32'h0, 0);
        chk("perf_full_addr", addr_a, 32'h8);
        drive_a(0, 1, 32'h200, 0);
        chk("perf_redir_valid", {31'b0, ifa.valid}, 32'd0);
        chk("perf_redir_addr", addr_a, 32'h200);
`ifdef FETCH_PERF_EN
        chk("perf_fetch_cnt", fcnt_a, 32'd2);
        chk("perf_flush_cnt", flcnt_a, 32'd2);
`endif

        // randomized run against the queue model
        model_step(1, 0, 32'h0, 1);
        drive_a(1, 0, 32'h0, 1);
        check_model();
        for (int n = 0; n < 400; n++) begin
            logic        r, rd, rdy;
            logic [31:0] rp;
            r   = ($urandom_range(0, 49) == 0);
            rd  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 1) == 1);
            rp  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            model_step(r, rd, rp, rdy);
            drive_a(r, rd, rp, rdy);
            check_model();
        end

        // instance B: PC wraps through zero, depth-4 fill
        rst_b = 1'b1; ifb.ready = 1'b1;
        tick_b();
        chk("b_rst_valid", {31'b0, ifb.valid}, 32'd0);
        chk("b_rst_addr", addr_b, 32'hFFFF_FFF8);
        rst_b = 1'b0;
        tick_b();
        chk("b_pc0", ifb.pc, 32'hFFFF_FFF8);
        chk("b_instr0", ifb.instr, rom(32'hFFFF_FFF8));
        tick_b();
        chk("b_pc1", ifb.pc, 32'hFFFF_FFFC);
        chk("b_addr1", addr_b, 32'h0);
        tick_b();
        chk("b_pc2", ifb.pc, 32'h0);
        chk("b_instr2", ifb.instr, 32'h1000_0000);
        ifb.ready = 1'b0;
        for (int k = 0; k < 5; k++) tick_b();
        chk("b_stall_pc", ifb.pc, 32'h0);
        chk("b_stall_addr", addr_b, 32'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end: the initiator side of the instruction-memory read interface.
- Holds the PC and drives a word address to the combinational instruction ROM every cycle.
- Captures the returned word with its PC into a small prefetch FIFO.
- Presents entries to decode over a valid/ready handshake; supports pipeline redirect (branch/jump) with flush.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- FIFO_DEPTH, 2: prefetch entries; power of two, >= 2.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- imem_addr_o  output  32  byte address to instruction memory; equals PC register.
- imem_data_i  input  32  instruction word; combinational response to imem_addr_o in the same cycle.
- redirect_i  input  1  redirect request from execute.
- redirect_pc_i  input  32  redirect target byte address.
- instr_o  output  32  instruction at FIFO head.
- pc_o  output  32  PC of instr_o.
- valid_o  output  1  FIFO non-empty.
- ready_i  input  1  decode accepts head this cycle.

Behaviour:
- Reset (rst_i high at an edge): PC <= RESET_PC, FIFO emptied. valid_o=0, instr_o=32'h0000_0013 (NOP), pc_o=0, imem_addr_o=RESET_PC. Reset mid-operation discards all entries; no handshake completes in a reset cycle.
- imem_addr_o = PC register, not gated; memory consumes only its low bits.
- pop = valid_o & ready_i.
- push = !redirect_i & (count < FIFO_DEPTH | pop). On push, FIFO tail <= {PC, imem_data_i} and PC <= PC + 4.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
- Full FIFO with pop: push and pop occur in the same cycle; count unchanged.
- Full FIFO without pop: no push; PC holds.
- Empty FIFO: valid_o=0, instr_o=NOP, pc_o=0; push allowed.
- Latency: a word is fetched in cycle N and appears at the head in cycle N+1. First valid_o is high in the cycle after rst_i deasserts.
- Redirect has priority over push and pop:
  - FIFO flushed, no push that cycle; any pop in that cycle does not count as a handshake.
  - PC <= {redirect_pc_i[31:2], 2'b00}; misaligned low bits are silently cleared.
  - valid_o=0 in the next cycle; the target instruction is valid two cycles after redirect_i.
- Back-to-back redirects: the last one wins; no entries survive.
- instr_o and pc_o must remain stable while valid_o & !ready_i & !redirect_i.
- No combinational path from ready_i or redirect_i to imem_addr_o.

Optional Feature:
- Macro: FETCH_PERF_EN.
- With it defined:
  - Adds outputs fetch_count_o[31:0] (increments on each push) and flush_count_o[31:0] (increments by the number of entries discarded on redirect).
  - Both counters reset to 0 and wrap modulo 2^32.
- Without it: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg:
  - XLEN=32, INSTR_NOP=32'h0000_0013, DEFAULT_RESET_PC.
  - Typedef fetch_entry_t {pc, instr} (64 bits).
- Sub-module fetch_fifo:
  - Parameterized synchronous FIFO of fetch_entry_t with push, pop, flush, count, full, empty.
  - Flush has priority over push and pop.
- fetch_unit owns the PC logic and instantiates fetch_fifo.

Test Plan:
- Reset, ready_i=1, ROM word k = 32'h1000_0000+k: pc_o/instr_o sequence 0/10000000, 4/10000001, 8/10000002 on consecutive cycles; valid_o high from the first cycle after reset.
- ready_i=0 for 5 cycles: FIFO fills to 2, imem_addr_o stalls at 8. head stays pc 0 for all 5 cycles. On release, pcs 0, 4, 8 delivered with no gap or duplicate.
- redirect_i with redirect_pc_i=32'h0000_0103 while FIFO full: next cycle valid_o=0, imem_addr_o=32'h100; the following cycle pc_o=32'h100.
- redirect_i asserted 2 consecutive cycles, targets 0x40 then 0x80: first valid entry has pc 0x80; 0x40 never appears.
- RESET_PC=32'hFFFF_FFF8, ready_i=1: pcs FFFFFFF8, FFFFFFFC, 00000000.
- rst_i pulsed while FIFO holds 2 entries: next cycle valid_o=0, imem_addr_o=RESET_PC. With FETCH_PERF_EN, fetch_count_o=0 and flush_count_o=0 after reset; after a redirect on a full FIFO, flush_count_o increments by 2.
